// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel-domain compositor.
package vga_pkg;

  localparam int   COLOR_BITS_DEF = 6;
  localparam int   FRAME_CNT_W    = 16;
  localparam logic SYNC_IDLE      = 1'b0;

  typedef struct packed {
    logic [COLOR_BITS_DEF-1:0] r;
    logic [COLOR_BITS_DEF-1:0] g;
    logic [COLOR_BITS_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low clear to a parametrised value.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) pipe_q <= {DEPTH{RST_VAL}};
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_compositor.sv
// Upscale + wrap-scroll framebuffer fetch, 1-bit layer overlay, sync alignment.
// Scroll registers exist only when VGA_COMPOSITOR_SCROLL_EN is defined.
module vga_frame_compositor
  import vga_pkg::*;
#(
  parameter int                      COLOR_BITS   = 6,
  parameter int                      FB_W_BITS    = 8,
  parameter int                      FB_H_BITS    = 8,
  parameter int                      SCALE_SHIFT  = 2,
  parameter int                      MEM_LATENCY  = 1,
  parameter int                      NUM_LAYERS   = 2,
  parameter logic [3*COLOR_BITS-1:0] BORDER_COLOR = '0
) (
  input  logic                               clk_pixel,
  input  logic                               rst_n,
  input  logic [11:0]                        vga_x,
  input  logic [11:0]                        vga_y,
  input  logic                               video_active,
  input  logic                               vga_hsync,
  input  logic                               vga_vsync,
  input  logic [FB_W_BITS-1:0]               scroll_x,
  input  logic [FB_H_BITS-1:0]               scroll_y,
  output logic                               read_en,
  output logic [FB_H_BITS+FB_W_BITS-1:0]     read_addr,
  input  logic [3*COLOR_BITS-1:0]            read_data,
  output logic [11:0]                        pix_x,
  output logic [11:0]                        pix_y,
  input  logic [NUM_LAYERS-1:0]              layer_mask,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_color,
  output logic [3*COLOR_BITS-1:0]            rgb_out,
  output logic                               hsync_out,
  output logic                               vsync_out,
  output logic [FRAME_CNT_W-1:0]             frame_cnt
);

  localparam int          PW    = 3*COLOR_BITS;
  localparam int          AW    = FB_H_BITS+FB_W_BITS;
  localparam logic [31:0] X_LIM = 32'd1 << (FB_W_BITS+SCALE_SHIFT);
  localparam logic [31:0] Y_LIM = 32'd1 << (FB_H_BITS+SCALE_SHIFT);

  logic [11:0]            pix_x_q, pix_y_q;
  logic                   act_q, inside_q, hs_q, vs_q, vs_prev_q;
  logic                   inside_c, frame_evt;
  logic                   read_en_q, read_en_d;
  logic [AW-1:0]          read_addr_q, read_addr_d;
  logic [FB_W_BITS-1:0]   off_x, col;
  logic [FB_H_BITS-1:0]   off_y, row;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]             dly;
  logic [PW-1:0]          rgb_q, rgb_d;
  logic                   hs_out_q, vs_out_q;

  assign frame_evt = vs_q & ~vs_prev_q;

`ifdef VGA_COMPOSITOR_SCROLL_EN
  logic [FB_W_BITS-1:0] scroll_x_q, scroll_x_d;
  logic [FB_H_BITS-1:0] scroll_y_q, scroll_y_d;

  // Offsets only move at frame boundaries so a frame never tears.
  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (frame_evt) begin
      scroll_x_d = scroll_x;
      scroll_y_d = scroll_y;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_q <= '0;
      scroll_y_q <= '0;
    end else begin
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
    end
  end

  assign off_x = scroll_x_q;
  assign off_y = scroll_y_q;
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_x, scroll_y};
  assign off_x = '0;
  assign off_y = '0;
`endif

  // Address is issued alongside stage 1 so read_data lands with the delayed flags.
  always_comb begin
    inside_c    = ({20'd0, vga_x} < X_LIM) && ({20'd0, vga_y} < Y_LIM);
    col         = vga_x[SCALE_SHIFT +: FB_W_BITS] + off_x;
    row         = vga_y[SCALE_SHIFT +: FB_H_BITS] + off_y;
    read_en_d   = video_active & inside_c;
    read_addr_d = read_en_d ? {row, col} : read_addr_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_evt) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      act_q       <= 1'b0;
      inside_q    <= 1'b0;
      hs_q        <= SYNC_IDLE;
      vs_q        <= SYNC_IDLE;
      vs_prev_q   <= SYNC_IDLE;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      pix_x_q     <= vga_x;
      pix_y_q     <= vga_y;
      act_q       <= video_active;
      inside_q    <= inside_c;
      hs_q        <= vga_hsync;
      vs_q        <= vga_vsync;
      vs_prev_q   <= vs_q;
      read_en_q   <= read_en_d;
      read_addr_q <= read_addr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vga_delay_line #(
    .WIDTH  (4),
    .DEPTH  (MEM_LATENCY),
    .RST_VAL({SYNC_IDLE, SYNC_IDLE, 2'b00})
  ) u_dly (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .din      ({vs_q, hs_q, inside_q, act_q}),
    .dout     (dly)
  );

  // Later layers overwrite earlier ones: highest index wins.
  always_comb begin
    rgb_d = '0;
    if (dly[0]) begin
      rgb_d = dly[1] ? read_data : BORDER_COLOR;
      for (int i = 0; i < NUM_LAYERS; i++)
        if (layer_mask[i]) rgb_d = layer_color[i*PW +: PW];
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= '0;
      hs_out_q <= SYNC_IDLE;
      vs_out_q <= SYNC_IDLE;
    end else begin
      rgb_q    <= rgb_d;
      hs_out_q <= dly[2];
      vs_out_q <= dly[3];
    end
  end

  assign read_en   = read_en_q;
  assign read_addr = read_addr_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign rgb_out   = rgb_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_compositor.sv
// Directed bench: two compositors (MEM_LATENCY 1 and 3) on shared stimulus, address-as-data memories.
module tb_vga_frame_compositor;

  localparam logic [17:0] BORDER = 18'h2A5A5;
  localparam logic [17:0] C0     = 18'h00F0F;
  localparam logic [17:0] C1     = 18'h3F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] vga_x, vga_y;
  logic        video_active, vga_hsync, vga_vsync;
  logic [7:0]  scroll_x, scroll_y;
  logic [1:0]  layer_mask;
  logic [35:0] layer_color;

  logic        ren1, ren2, hs1, hs2, vs1, vs2;
  logic [15:0] raddr1, raddr2, fc1, fc2;
  logic [17:0] rd1, rd2, rgb1, rgb2;
  logic [11:0] px1, py1, px2, py2;
  logic [17:0] mp1;
  logic [17:0] mp2 [3];

  int tests_run = 0;
  int tests_failed = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  vga_frame_compositor #(.MEM_LATENCY(1), .BORDER_COLOR(BORDER)) dut1 (
    .clk_pixel(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y),
    .video_active(video_active), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .read_en(ren1), .read_addr(raddr1),
    .read_data(rd1), .pix_x(px1), .pix_y(py1), .layer_mask(layer_mask),
    .layer_color(layer_color), .rgb_out(rgb1), .hsync_out(hs1), .vsync_out(vs1),
    .frame_cnt(fc1));

  vga_frame_compositor #(.MEM_LATENCY(3), .BORDER_COLOR(BORDER)) dut2 (
    .clk_pixel(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y),
    .video_active(video_active), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .read_en(ren2), .read_addr(raddr2),
    .read_data(rd2), .pix_x(px2), .pix_y(py2), .layer_mask(layer_mask),
    .layer_color(layer_color), .rgb_out(rgb2), .hsync_out(hs2), .vsync_out(vs2),
    .frame_cnt(fc2));

  // Framebuffer holds its own address; unread cycles return a poison word.
  always @(posedge clk) begin
    mp1    <= ren1 ? 18'(raddr1) : 18'h3FFFF;
    mp2[0] <= ren2 ? 18'(raddr2) : 18'h3FFFF;
    mp2[1] <= mp2[0];
    mp2[2] <= mp2[1];
  end
  assign rd1 = mp1;
  assign rd2 = mp2[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_x = 0; vga_y = 0; video_active = 0; vga_hsync = 0; vga_vsync = 0; layer_mask = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); scroll_x = 0; scroll_y = 0; layer_color = {C1, C0};
    #1;
    tests_run++; if (rgb1 !== 18'd0) begin tests_failed++; $display("FAIL rst_rgb1 got %h exp 0", rgb1); end
    tests_run++; if ({hs1, vs1, ren1} !== 3'b000) begin tests_failed++; $display("FAIL rst_ctl1 got %b exp 000", {hs1, vs1, ren1}); end
    tests_run++; if (raddr1 !== 16'd0 || fc1 !== 16'd0) begin tests_failed++; $display("FAIL rst_addr_fc got %h/%h exp 0/0", raddr1, fc1); end
    tests_run++; if (px1 !== 12'd0 || py1 !== 12'd0) begin tests_failed++; $display("FAIL rst_pix got %h/%h exp 0/0", px1, py1); end
    step(); step();
    tests_run++; if (rgb2 !== 18'd0 || hs2 !== 1'b0) begin tests_failed++; $display("FAIL rst_dut2 got %h/%b exp 0/0", rgb2, hs2); end
    rst_n = 1;
    step(); step(); step(); step();
  endtask

  task automatic test_latency();
    video_active = 1; vga_y = 0; vga_x = 4; step();
    tests_run++; if (px1 !== 12'd4 || ren1 !== 1'b1 || raddr1 !== 16'd1) begin tests_failed++; $display("FAIL lat_addr got px=%0d en=%b a=%h exp 4/1/1", px1, ren1, raddr1); end
    vga_x = 8; step();
    vga_x = 12; step();
    tests_run++; if (rgb1 !== 18'd1) begin tests_failed++; $display("FAIL lat_rgb1_a got %h exp 1", rgb1); end
    video_active = 0; vga_x = 0; step();
    tests_run++; if (rgb1 !== 18'd2 || rgb2 !== 18'd0) begin tests_failed++; $display("FAIL lat_rgb_b got %h/%h exp 2/0", rgb1, rgb2); end
    tests_run++; if (ren1 !== 1'b0 || raddr1 !== 16'd3) begin tests_failed++; $display("FAIL lat_hold got en=%b a=%h exp 0/3", ren1, raddr1); end
    step();
    tests_run++; if (rgb1 !== 18'd3 || rgb2 !== 18'd1) begin tests_failed++; $display("FAIL lat_rgb_c got %h/%h exp 3/1", rgb1, rgb2); end
    step();
    tests_run++; if (rgb1 !== 18'd0 || rgb2 !== 18'd2) begin tests_failed++; $display("FAIL lat_rgb_d got %h/%h exp 0/2", rgb1, rgb2); end
    step();
    tests_run++; if (rgb2 !== 18'd3) begin tests_failed++; $display("FAIL lat_rgb2_e got %h exp 3", rgb2); end
    step();
    tests_run++; if (rgb2 !== 18'd0) begin tests_failed++; $display("FAIL lat_rgb2_f got %h exp 0", rgb2); end
  endtask

  task automatic test_sync();
    vga_hsync = 1; vga_vsync = 1; step();
    tests_run++; if (fc1 !== 16'd0) begin tests_failed++; $display("FAIL sync_fc_pre got %0d exp 0", fc1); end
    vga_hsync = 0; vga_vsync = 0; step();
    exp_frames++;
    tests_run++; if (hs1 !== 1'b0 || fc1 !== 16'(exp_frames)) begin tests_failed++; $display("FAIL sync_c2 got hs=%b fc=%0d exp 0/%0d", hs1, fc1, exp_frames); end
    step();
    tests_run++; if ({hs1, vs1, hs2} !== 3'b110) begin tests_failed++; $display("FAIL sync_c3 got %b exp 110", {hs1, vs1, hs2}); end
    step();
    tests_run++; if ({hs1, hs2} !== 2'b00) begin tests_failed++; $display("FAIL sync_c4 got %b exp 00", {hs1, hs2}); end
    step();
    tests_run++; if ({hs2, vs2} !== 2'b11) begin tests_failed++; $display("FAIL sync_c5 got %b exp 11", {hs2, vs2}); end
    step();
    tests_run++; if (hs2 !== 1'b0 || fc2 !== 16'(exp_frames)) begin tests_failed++; $display("FAIL sync_c6 got hs=%b fc=%0d exp 0/%0d", hs2, fc2, exp_frames); end
  endtask

  task automatic test_border();
    video_active = 1; vga_x = 1024; vga_y = 0; step();
    tests_run++; if (ren1 !== 1'b0) begin tests_failed++; $display("FAIL bord_ren got %b exp 0", ren1); end
    vga_x = 1023; step();
    tests_run++; if (ren1 !== 1'b1 || raddr1 !== 16'd255) begin tests_failed++; $display("FAIL bord_edge_addr got %b/%h exp 1/ff", ren1, raddr1); end
    vga_x = 0; vga_y = 1024; step();
    tests_run++; if (rgb1 !== BORDER) begin tests_failed++; $display("FAIL bord_x got %h exp %h", rgb1, BORDER); end
    video_active = 0; vga_y = 0; step();
    tests_run++; if (rgb1 !== 18'd255) begin tests_failed++; $display("FAIL bord_last_col got %h exp ff", rgb1); end
    step();
    tests_run++; if (rgb1 !== BORDER || rgb2 !== BORDER) begin tests_failed++; $display("FAIL bord_y got %h/%h exp %h", rgb1, rgb2, BORDER); end
    step();
    tests_run++; if (rgb1 !== 18'd0 || rgb2 !== 18'd255) begin tests_failed++; $display("FAIL bord_tail got %h/%h exp 0/ff", rgb1, rgb2); end
    step(); step();
  endtask

  task automatic test_layers();
    video_active = 1; vga_x = 4; vga_y = 0; layer_mask = 2'b00;
    repeat (5) step();
    tests_run++; if (rgb1 !== 18'd1 || rgb2 !== 18'd1) begin tests_failed++; $display("FAIL lay_none got %h/%h exp 1/1", rgb1, rgb2); end
    layer_mask = 2'b11; step();
    tests_run++; if (rgb1 !== C1 || rgb2 !== C1) begin tests_failed++; $display("FAIL lay_11 got %h/%h exp %h", rgb1, rgb2, C1); end
    layer_mask = 2'b01; step();
    tests_run++; if (rgb1 !== C0 || rgb2 !== C0) begin tests_failed++; $display("FAIL lay_01 got %h/%h exp %h", rgb1, rgb2, C0); end
    layer_mask = 2'b10; step();
    tests_run++; if (rgb1 !== C1) begin tests_failed++; $display("FAIL lay_10 got %h exp %h", rgb1, C1); end
    layer_mask = 2'b11; video_active = 0;
    repeat (5) step();
    tests_run++; if (rgb1 !== 18'd0 || rgb2 !== 18'd0) begin tests_failed++; $display("FAIL lay_inactive got %h/%h exp 0", rgb1, rgb2); end
    layer_mask = 2'b01; video_active = 1; vga_x = 1024;
    repeat (5) step();
    tests_run++; if (rgb1 !== C0) begin tests_failed++; $display("FAIL lay_border got %h exp %h", rgb1, C0); end
    layer_mask = 2'b00; step();
    tests_run++; if (rgb1 !== BORDER) begin tests_failed++; $display("FAIL lay_clear got %h exp %h", rgb1, BORDER); end
    idle_inputs(); repeat (5) step();
  endtask

  task automatic test_scroll();
    logic [17:0] e0, e1, e2;
`ifdef VGA_COMPOSITOR_SCROLL_EN
    e0 = 18'd511; e1 = 18'd256; e2 = 18'h0FF01;
`else
    e0 = 18'd256; e1 = 18'd257; e2 = 18'd1;
`endif
    scroll_x = 8'd255; scroll_y = 8'd0;
    video_active = 1; vga_y = 4; vga_x = 0; step();
    vga_x = 4; step();
    idle_inputs(); step();
    tests_run++; if (rgb1 !== 18'd256) begin tests_failed++; $display("FAIL scr_mid_x0 got %h exp 100", rgb1); end
    step();
    tests_run++; if (rgb1 !== 18'd257) begin tests_failed++; $display("FAIL scr_mid_x4 got %h exp 101", rgb1); end
    step(); step();
    vga_vsync = 1; step(); vga_vsync = 0; step();
    exp_frames++;
    tests_run++; if (fc1 !== 16'(exp_frames)) begin tests_failed++; $display("FAIL scr_fc got %0d exp %0d", fc1, exp_frames); end
    video_active = 1; vga_y = 4; vga_x = 0; step();
    vga_x = 4; step();
    idle_inputs(); step();
    tests_run++; if (rgb1 !== e0) begin tests_failed++; $display("FAIL scr_next_x0 got %h exp %h", rgb1, e0); end
    step();
    tests_run++; if (rgb1 !== e1) begin tests_failed++; $display("FAIL scr_next_x4 got %h exp %h", rgb1, e1); end
    step(); step();
    scroll_x = 8'd0; scroll_y = 8'd255;
    vga_vsync = 1; step(); vga_vsync = 0; step();
    exp_frames++;
    video_active = 1; vga_y = 0; vga_x = 4; step();
    idle_inputs(); step(); step();
    tests_run++; if (rgb1 !== e2) begin tests_failed++; $display("FAIL scr_ywrap got %h exp %h", rgb1, e2); end
    step(); step();
    tests_run++; if (rgb2 !== e2 || fc2 !== 16'(exp_frames)) begin tests_failed++; $display("FAIL scr_ywrap2 got %h/%0d exp %h/%0d", rgb2, fc2, e2, exp_frames); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
`ifdef VGA_COMPOSITOR_SCROLL_EN
    e = 18'd263;
`else
    e = 18'd256;
`endif
    video_active = 1; vga_x = 4; vga_y = 0; vga_hsync = 1;
    repeat (5) step();
    tests_run++; if (rgb1 !== 18'd1 || hs1 !== 1'b1 || hs2 !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre got %h/%b/%b exp 1/1/1", rgb1, hs1, hs2); end
    #3 rst_n = 0;
    #1;
    tests_run++; if (rgb1 !== 18'd0 || rgb2 !== 18'd0 || hs1 !== 1'b0 || hs2 !== 1'b0) begin tests_failed++; $display("FAIL rmid_async got %h/%h/%b/%b exp 0", rgb1, rgb2, hs1, hs2); end
    tests_run++; if (fc1 !== 16'd0 || ren1 !== 1'b0 || px1 !== 12'd0) begin tests_failed++; $display("FAIL rmid_regs got fc=%0d en=%b px=%0d exp 0", fc1, ren1, px1); end
    exp_frames = 0;
    @(posedge clk); #1;
    rst_n = 1; vga_hsync = 0; scroll_x = 8'd7; scroll_y = 8'd0;
    vga_x = 0; vga_y = 4;
    repeat (3) step();
    tests_run++; if (rgb1 !== 18'd256) begin tests_failed++; $display("FAIL rmid_noscroll got %h exp 100", rgb1); end
    step(); step();
    tests_run++; if (rgb2 !== 18'd256 || fc1 !== 16'd0) begin tests_failed++; $display("FAIL rmid_dut2 got %h/%0d exp 100/0", rgb2, fc1); end
    vga_vsync = 1; step(); vga_vsync = 0; step();
    exp_frames++;
    tests_run++; if (fc1 !== 16'(exp_frames) || fc2 !== 16'(exp_frames)) begin tests_failed++; $display("FAIL rmid_fc got %0d/%0d exp %0d", fc1, fc2, exp_frames); end
    repeat (3) step();
    tests_run++; if (rgb1 !== e) begin tests_failed++; $display("FAIL rmid_scroll got %h exp %h", rgb1, e); end
    step(); step();
    tests_run++; if (rgb2 !== e) begin tests_failed++; $display("FAIL rmid_scroll2 got %h exp %h", rgb2, e); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sync();
    test_border();
    test_layers();
    test_scroll();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
